clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, bit width of the half-period ratio and counter.
REQ-002 Parameter DEFAULT_DIV, default 5, half-period ratio loaded at reset.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  run request for the divided clock.
REQ-006 div_req  input  1  ratio-change request; held high until div_ack.
REQ-007 div_val  input  WIDTH  requested half-period ratio N; sampled on the request-accept cycle.
REQ-008 div_ack  output  1  one-cycle pulse on the cycle the new ratio takes effect.
REQ-009 busy  output  1  high while a request is latched and not yet applied.
REQ-010 cur_div  output  WIDTH  ratio currently in effect.
REQ-011 clk_div  output  1  divided clock, registered, period 2*cur_div clk cycles, 50% duty.

Function
REQ-012 States SHALL be STOP, RUN, PEND; the encoding is free.
REQ-013 STOP: clk_div=0, cnt=0; STOP->RUN when enable=1 and cur_div!=0, with the first clk_div rise after cur_div cycles.
REQ-014 RUN: cnt increments each cycle; at cnt==cur_div-1, clk_div toggles and cnt clears.
REQ-015 Boundary = RUN/PEND cycle in which clk_div toggles 1->0; ratio changes and stops occur only at a boundary, so no runt pulses.
REQ-016 RUN with div_req=1 and busy=0: latch div_val, go to PEND, busy=1 next cycle.
REQ-017 PEND: continue counting with the old ratio; at the boundary load cur_div from the latch, pulse div_ack, clear busy, return to RUN; the following low phase uses the new ratio.
REQ-018 STOP with div_req=1: load cur_div and pulse div_ack on the next edge (1-cycle latency), with no PEND.
REQ-019 enable=0 in RUN/PEND: go to STOP at the next boundary; clk_div remains high until then.
REQ-020 Accepted div_val=0: applied at the boundary, then STOP, clk_div held 0 regardless of enable.
REQ-021 Pending request and enable=0 at the same boundary: apply ratio, pulse div_ack, then STOP.
REQ-022 div_req while busy=1: ignored until div_ack; at most one request is outstanding.
REQ-023 div_req that stays high after div_ack SHALL be treated as a new request on the following cycle.
REQ-024 cnt SHALL be WIDTH bits, comparisons unsigned; cur_div=1 gives clk_div toggling every cycle (period 2).

Reset
REQ-025 rst=1 SHALL immediately force STOP, cnt=0, clk_div=0, div_ack=0, busy=0, cur_div=DEFAULT_DIV.
REQ-026 Reset mid-operation SHALL discard any latched request with no div_ack; operation resumes per REQ-013 after release.

Configuration
REQ-027 Macro CLK_DIV_CTRL_TICK_EN, when defined, SHALL add output port tick (1 bit), a one-cycle pulse coincident with each clk_div 0->1 registered transition; reset value 0.
REQ-028 Without CLK_DIV_CTRL_TICK_EN the tick port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 DEFAULT_DIV=5, rst 1->0, enable=1 -> clk_div first rises 5 cycles after leaving STOP, then has a period of 10 cycles with 5 high and 5 low.
REQ-030 div_req=1, div_val=3 during the high phase -> busy=1; div_ack pulses at the 1->0 toggle; cur_div=3; the subsequent period is 6 cycles.
REQ-031 enable=0 with no prior run, div_req=1, div_val=7 -> div_ack next cycle, cur_div=7; then enable=1 -> first rise after 7 cycles.
REQ-032 div_val=0 accepted in RUN -> clk_div falls at the boundary and stays 0 with enable=1; STOP is entered.
REQ-033 rst pulse while busy=1 -> no div_ack; cur_div=5; clk_div=0 immediately.
REQ-034 CLK_DIV_CTRL_TICK_EN defined, cur_div=2 -> tick pulses every 4 cycles, aligned with clk_div rises; a second div_req while busy is ignored.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable 50% duty clock divider with glitch-free ratio change handshake
// Optional feature macro: CLK_DIV_CTRL_TICK_EN adds a one-cycle tick output on each clk_div rise.
module clk_div_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             div_req,
  input  logic [WIDTH-1:0] div_val,
  output logic             div_ack,
  output logic             busy,
  output logic [WIDTH-1:0] cur_div,
  output logic             clk_div
`ifdef CLK_DIV_CTRL_TICK_EN
  ,
  output logic             tick
`endif
);

  typedef enum logic [1:0] {STOP, RUN, PEND} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_latch;
  logic             terminal;
  logic             boundary;
  logic             accept;

  // terminal: this cycle ends a half period; boundary: the end of a high phase
  // accept: a new request may be taken (never on the cycle its previous ack is visible)
  assign terminal = (cnt == cur_div - WIDTH'(1));
  assign boundary = terminal && clk_div;
  assign accept   = div_req && !busy && !div_ack;

  // Control FSM: counting, ratio handshake and run/stop sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STOP;
      cnt       <= '0;
      clk_div   <= 1'b0;
      div_ack   <= 1'b0;
      busy      <= 1'b0;
      cur_div   <= WIDTH'(DEFAULT_DIV);
      div_latch <= '0;
    end else begin
      div_ack <= 1'b0;
      case (state)
        STOP: begin
          clk_div <= 1'b0;
          cnt     <= '0;
          // Idle: ratio changes apply directly with no boundary to wait for
          if (div_req && !div_ack) begin
            cur_div <= div_val;
            div_ack <= 1'b1;
          end else if (enable && (cur_div != '0)) begin
            state <= RUN;
          end
        end
        RUN, PEND: begin
          if (terminal) begin
            clk_div <= ~clk_div;
            cnt     <= '0;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
          if (boundary) begin
            if (state == PEND) begin
              // Apply latched ratio; the low phase now starting uses it
              cur_div <= div_latch;
              div_ack <= 1'b1;
              busy    <= 1'b0;
              if (!enable || (div_latch == '0)) state <= STOP;
              else                              state <= RUN;
            end else if (!enable) begin
              // A request arriving here is served from STOP on the next cycle
              state <= STOP;
            end else if (accept) begin
              div_latch <= div_val;
              busy      <= 1'b1;
              state     <= PEND;
            end
          end else if ((state == RUN) && accept) begin
            div_latch <= div_val;
            busy      <= 1'b1;
            state     <= PEND;
          end
        end
        default: state <= STOP;
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_TICK_EN
  // Tick marks the edge where clk_div goes 0->1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= (state != STOP) && terminal && !clk_div;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       div_req;
  logic [7:0] div_val;
  logic       div_ack;
  logic       busy;
  logic [7:0] cur_div;
  logic       clk_div;
`ifdef CLK_DIV_CTRL_TICK_EN
  logic       tick;
`endif

  int errors = 0;
  int checks = 0;
  int n;
  int highs;
  int acks;

  clk_div_ctrl #(.WIDTH(8), .DEFAULT_DIV(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .busy    (busy),
    .cur_div (cur_div),
    .clk_div (clk_div)
`ifdef CLK_DIV_CTRL_TICK_EN
    ,
    .tick    (tick)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles until clk_div equals v (capped at 100)
  task automatic wait_clk(input logic v, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (clk_div !== v && cnt < 100);
  endtask

  // Cycles until div_ack is seen high (capped at 100)
  task automatic wait_ack(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (div_ack !== 1'b1 && cnt < 100);
  endtask

  // Count clk_div high cycles over a window
  task automatic count_highs(input int len, output int h);
    h = 0;
    for (int i = 0; i < len; i++) begin
      step();
      if (clk_div) h++;
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; div_req = 1'b0; div_val = 8'd0;
    step(); step();
    check("rst_clk_div", clk_div, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", div_ack, 0);
    check("rst_cur_div", cur_div, 5);

    // Default ratio 5: first rise 5 cycles after leaving STOP, then 5/5
    rst = 1'b0; enable = 1'b1;
    step();
    wait_clk(1'b1, n); check("first_rise_5", n, 5);
    wait_clk(1'b0, n); check("high_5", n, 5);
    wait_clk(1'b1, n); check("low_5", n, 5);

    // Request 3 during high phase; second value while busy is ignored
    div_req = 1'b1; div_val = 8'd3;
    step();
    check("busy_set", busy, 1);
    check("no_early_ack", div_ack, 0);
    div_val = 8'd9;
    wait_ack(n);
    check("ack_at_fall", n, 4);
    check("ack_clk_low", clk_div, 0);
    check("cur_div_3", cur_div, 3);
    check("busy_clear", busy, 0);
    div_req = 1'b0;
    wait_clk(1'b1, n); check("low_3", n, 3);
    wait_clk(1'b0, n); check("high_3", n, 3);

    // Ratio 0 accepted in RUN: apply at boundary, then stay stopped
    div_req = 1'b1; div_val = 8'd0;
    wait_ack(n);
    check("ack_div0", n, 6);
    check("div0_clk_low", clk_div, 0);
    check("cur_div_0", cur_div, 0);
    div_req = 1'b0;
    count_highs(20, highs);
    check("div0_stays_low", highs, 0);

    // STOP request: ack on the next edge
    enable = 1'b0; div_req = 1'b1; div_val = 8'd7;
    step();
    check("stop_ack", div_ack, 1);
    check("stop_cur_div_7", cur_div, 7);
    div_req = 1'b0;
    step();
    check("stop_ack_pulse", div_ack, 0);
    enable = 1'b1;
    step();
    wait_clk(1'b1, n); check("first_rise_7", n, 7);
    wait_clk(1'b0, n); check("high_7", n, 7);

    // Disable while high: stays high to the boundary, then stops
    wait_clk(1'b1, n); check("low_7", n, 7);
    enable = 1'b0;
    wait_clk(1'b0, n); check("disable_full_high", n, 7);
    count_highs(10, highs);
    check("disable_stopped", highs, 0);

    // Pending request and disable at the same boundary
    enable = 1'b1;
    step();
    wait_clk(1'b1, n); check("restart_rise_7", n, 7);
    div_req = 1'b1; div_val = 8'd2;
    step();
    check("pend_busy", busy, 1);
    enable = 1'b0;
    wait_ack(n);
    check("pend_stop_ack", n, 6);
    check("pend_stop_clk", clk_div, 0);
    check("pend_stop_cur", cur_div, 2);
    div_req = 1'b0;
    count_highs(10, highs);
    check("pend_stop_low", highs, 0);

    // Held request after ack becomes a new request
    div_req = 1'b1; div_val = 8'd4;
    step();
    check("hold_ack1", div_ack, 1);
    check("hold_cur4", cur_div, 4);
    div_val = 8'd6;
    step();
    check("hold_gap", div_ack, 0);
    step();
    check("hold_ack2", div_ack, 1);
    check("hold_cur6", cur_div, 6);
    div_req = 1'b0;
    step();

    // Ratio 1: period 2
    div_req = 1'b1; div_val = 8'd1;
    step();
    check("div1_ack", div_ack, 1);
    div_req = 1'b0; enable = 1'b1;
    step();
    wait_clk(1'b1, n); check("div1_rise", n, 1);
    wait_clk(1'b0, n); check("div1_high", n, 1);
    wait_clk(1'b1, n); check("div1_low", n, 1);

    // Reset while busy: request discarded, defaults restored at once
    div_req = 1'b1; div_val = 8'd9;
    step();
    check("rst_case_busy", busy, 1);
    #2 rst = 1'b1; div_req = 1'b0; enable = 1'b0;
    #1;
    check("async_clk_div", clk_div, 0);
    check("async_busy", busy, 0);
    check("async_cur_div", cur_div, 5);
    step();
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (div_ack) acks++;
    end
    check("rst_no_ack", acks, 0);
    check("rst_cur_kept", cur_div, 5);

`ifdef CLK_DIV_CTRL_TICK_EN
    // Tick with ratio 2: coincident with every rise, period 4
    div_req = 1'b1; div_val = 8'd2;
    step();
    div_req = 1'b0; enable = 1'b1;
    step();
    check("tick_idle", tick, 0);
    wait_clk(1'b1, n); check("tick_rise_2", n, 2);
    check("tick_at_rise1", tick, 1);
    wait_clk(1'b0, n); check("tick_high_2", n, 2);
    check("tick_at_fall", tick, 0);
    wait_clk(1'b1, n); check("tick_low_2", n, 2);
    check("tick_at_rise2", tick, 1);
    step();
    check("tick_pulse", tick, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
